// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle RV32M divider.
package div_pkg;

    // Default operand width; the iteration count tracks it.
    localparam int unsigned DataWidth = 32;
    localparam int unsigned DivIter   = DataWidth;
    localparam int unsigned CntWidth  = $clog2(DataWidth) + 1;

    // Operation encoding as driven by the control unit.
    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_t;

    // DIV and REM treat operands as two's complement.
    function automatic logic op_is_signed(input div_op_t op);
        return (op == OpDiv) || (op == OpRem);
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic op_is_rem(input div_op_t op);
        return (op == OpRem) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] rem_i,
    input  logic [Width-1:0] quo_i,
    input  logic [Width-1:0] divisor_i,
    output logic [Width-1:0] rem_o,
    output logic [Width-1:0] quo_o
);

    logic [Width:0] shift_rem;
    logic [Width:0] trial;

    // Trial is one bit wider so its MSB is a reliable sign: rem < divisor keeps it in range.
    always_comb begin
        shift_rem = {rem_i, quo_i[Width-1]};
        trial     = shift_rem - {1'b0, divisor_i};
        if (trial[Width]) begin
            rem_o = shift_rem[Width-1:0];
        end else begin
            rem_o = trial[Width-1:0];
        end
        quo_o = {quo_i[Width-2:0], ~trial[Width]};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) with early exit for
// divide-by-zero and signed overflow.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = div_pkg::DataWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            DivOp,
    input  logic [DATA_WIDTH-1:0] DivOp1,
    input  logic [DATA_WIDTH-1:0] DivOp2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] DivOut
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(DATA_WIDTH - 1);

    div_state_t            state_q, state_d;
    div_op_t               op_q, op_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0] div_out_q, div_out_d;

    div_op_t               op_in;
    logic                  in_signed;
    logic                  in_rem;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] mag1;
    logic [DATA_WIDTH-1:0] mag2;
    logic [DATA_WIDTH-1:0] special_res;
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quo;
    logic [DATA_WIDTH-1:0] final_res;

    div_step #(
        .Width(DATA_WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(divisor_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    // Decode the incoming request and resolve the early-exit cases.
    always_comb begin
        op_in     = div_op_t'(DivOp);
        in_signed = op_is_signed(op_in);
        in_rem    = op_is_rem(op_in);
        div_zero  = (DivOp2 == '0);
        // Most-negative dividend over -1 does not fit; RISC-V defines the result.
        overflow  = in_signed && (DivOp1 == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (DivOp2 == '1);
        mag1      = (in_signed && DivOp1[DATA_WIDTH-1]) ? (~DivOp1 + 1'b1) : DivOp1;
        mag2      = (in_signed && DivOp2[DATA_WIDTH-1]) ? (~DivOp2 + 1'b1) : DivOp2;
        if (div_zero) begin
            special_res = in_rem ? DivOp1 : '1;
        end else begin
            special_res = in_rem ? '0 : DivOp1;
        end
    end

    // Sign fix-up applied to the last iteration's outputs as they are loaded.
    always_comb begin
        if (op_is_rem(op_q)) begin
            final_res = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
        end else begin
            final_res = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        end
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_out_d = div_out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d      = op_in;
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = mag1;
                    divisor_d = mag2;
                    neg_quo_d = in_signed && (DivOp1[DATA_WIDTH-1] ^ DivOp2[DATA_WIDTH-1]);
                    neg_rem_d = in_signed && DivOp1[DATA_WIDTH-1];
                    if (div_zero || overflow) begin
                        state_d   = StDone;
                        div_out_d = special_res;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d   = StDone;
                    div_out_d = final_res;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpDiv;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_out_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div_out_q <= div_out_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        DivOut = div_out_q;
    end

endmodule
